// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: size encodings
// and byte-mask / alignment helpers.
package store_buffer_pkg;

  localparam int MASK_W = 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [MASK_W-1:0] size_to_mask(
    input logic [1:0] size
  );
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [2:0] addr_lo
  );
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo[1:0];
      SZ_D:    return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places right-aligned store data into its byte lanes of
// an 8-byte beat and flags misaligned accesses.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [63:0]       data,
  output logic [63:0]       lane_data,
  output logic [MASK_W-1:0] lane_mask,
  output logic              misaligned
);

  logic [MASK_W-1:0] base;
  logic [63:0]       keep;

  always_comb begin
    base = size_to_mask(size);
    keep = '0;
    for (int i = 0; i < MASK_W; i++) begin
      keep[8*i +: 8] = {8{base[i]}};
    end
    lane_mask  = base << addr_lo;
    lane_data  = (data & keep) << {addr_lo, 3'b000};
    misaligned = is_misaligned(size, addr_lo);
  end

endmodule

// File: rtl/store_buffer.sv
// Store queue between execute and memory: aligns stores into
// beats, drains them in order, flags overlapping loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_wvalid,
  input  logic                     mem_wready,
  output logic [AW-1:0]            mem_waddr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW/8-1:0]          mem_wmask,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hazard,
  output logic                     misalign_err,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-4:0]   ent_addr [DEPTH];
  logic [DW-1:0]   ent_data [DEPTH];
  logic [DW/8-1:0] ent_mask [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_nxt;

  logic [DW-1:0]   lane_data;
  logic [DW/8-1:0] lane_mask;
  logic            misaligned;
  logic            st_fire, enq, deq, hit;

  store_lane_align u_align (
    .addr_lo    (st_addr[2:0]),
    .size       (st_size),
    .data       (st_data),
    .lane_data  (lane_data),
    .lane_mask  (lane_mask),
    .misaligned (misaligned)
  );

  assign st_ready  = (count != CW'(DEPTH));
  assign st_fire   = st_valid && st_ready;
  assign enq       = st_fire && !misaligned;
  assign deq       = mem_wvalid && mem_wready;
  assign count_nxt = count + CW'(enq) - CW'(deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      ent_vld      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= st_fire && misaligned;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      if (deq) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (enq) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only visible behind ent_vld/empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= st_addr[AW-1:3];
      ent_data[wr_ptr] <= lane_data;
      ent_mask[wr_ptr] <= lane_mask;
    end
  end

  assign mem_wvalid = !empty;

  always_comb begin
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (mem_wvalid) begin
      mem_waddr = {ent_addr[rd_ptr], 3'b000};
      mem_wdata = ent_data[rd_ptr];
      mem_wmask = ent_mask[rd_ptr];
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == ld_addr[AW-1:3]) begin
        hit = 1'b1;
      end
    end
    ld_hazard = ld_valid && hit;
  end

  logic unused_lo;
  assign unused_lo = ^ld_addr[2:0];

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Write-side counterpart of the load path in the ALU/memory stage.
- Accepts store requests (address, data, size) from the execute stage and converts each to an 8-byte-aligned, lane-shifted beat with a byte mask.
- Queues beats in a small FIFO and drains them to physical memory over a valid/ready write port; the memory side wraps the `pmem_write` DPI call.
- Flags younger loads that overlap a pending store so the pipeline can stall instead of reading stale memory.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
AW, 64, address width.
DW, 64, data width; fixed at 64, and the mask is DW/8 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
st_valid  input  1  store request valid.
st_ready  output  1  buffer can accept a store.
st_addr  input  64  byte address of the store.
st_data  input  64  store data, right-aligned: the byte/half/word sits in the low bits.
st_size  input  2  0 = sb, 1 = sh, 2 = sw, 3 = sd.
mem_wvalid  output  1  head entry presented to memory.
mem_wready  input  1  memory accepts the beat.
mem_waddr  output  64  head address with bits [2:0] forced to 0.
mem_wdata  output  64  lane-shifted head data.
mem_wmask  output  8  byte-enable mask of the head.
ld_valid  input  1  a load is being issued this cycle.
ld_addr  input  64  load byte address.
ld_hazard  output  1  load overlaps a pending store doubleword.
misalign_err  output  1  one-cycle pulse: a misaligned store was dropped.
empty  output  1  no pending entries.
count  output  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset (async, rst_n=0):
  - rd_ptr, wr_ptr and count clear to 0.
  - All entry-valid bits clear; stores pending at reset are discarded.
  - Outputs after reset: mem_wvalid=0, mem_waddr=0, mem_wdata=0, mem_wmask=0, misalign_err=0, st_ready=1, empty=1, ld_hazard=0.
- Alignment rules:
  - sh requires addr[0]=0; sw requires addr[1:0]=0; sd requires addr[2:0]=0.
  - sb is always aligned.
- Enqueue:
  - Fires when st_valid && st_ready; st_ready = (count != DEPTH).
  - Aligned store: entry written at wr_ptr, wr_ptr increments and wraps modulo DEPTH.
  - Stored mask = base_mask << addr[2:0], with base_mask 0x01 / 0x03 / 0x0F / 0xFF for sb / sh / sw / sd.
  - Stored data = (st_data & size_mask) << (8*addr[2:0]), where size_mask keeps only the low 1/2/4/8 bytes.
  - Stored address = {addr[63:3], 3'b000}.
  - Misaligned store: handshake still completes (consumed) but nothing is enqueued; misalign_err is high for exactly the next cycle.
- Dequeue:
  - mem_wvalid = !empty; mem_w* are driven from the entry at rd_ptr.
  - On mem_wvalid && mem_wready, rd_ptr increments.
  - mem_w* must stay stable while mem_wvalid=1 and mem_wready=0.
  - While empty, mem_w* are held at 0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full case: st_ready=0 even if a dequeue happens in the same cycle (no bypass). The new store is accepted the following cycle.
- Empty case: no bypass. A store enqueued at cycle N appears on mem_wvalid at N+1 at the earliest.
- Hazard: ld_hazard = ld_valid && (any valid entry with entry_addr[63:3] == ld_addr[63:3]). It is combinational and ignores masks (conservative).
  - An entry leaving the queue in the same cycle still counts as a hazard.
- Count: count and empty are registered and consistent with the pointers; count never exceeds DEPTH.

Decomposition:
- Shared package holds:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - Function size_to_mask(size) returning the 8-bit base mask.
  - Function is_misaligned(size, addr_lo).
  - Localparam MASK_W = 8.
- One natural sub-module: store_lane_align, the combinational shift of data and mask plus the misalignment check. It feeds the FIFO write port.
- The FIFO storage lives in store_buffer itself.

Test Plan:
- sb addr=0x8000_0005 data=0xAB → beat waddr=0x8000_0000, wmask=0x20, wdata=0x0000_AB00_0000_0000.
- sh addr=0x8000_0003 → st_ready=1, misalign_err pulses 1 cycle, count stays 0, mem_wvalid stays 0.
- Hold mem_wready=0 and enqueue 5 sd stores (DEPTH=4) → st_ready drops after 4, count=4. Raise mem_wready → beats drain in order at 1 per cycle and the 5th store is accepted.
- Pending sw at 0x8000_1004: ld_valid with ld_addr=0x8000_1000 → ld_hazard=1; ld_addr=0x8000_1008 → ld_hazard=0.
- Enqueue and dequeue every cycle for 20 cycles with count=2 → count stays 2, pointer wrap-around is correct, data order is preserved.
- With 3 entries pending, assert rst_n=0 mid-cycle → outputs clear immediately, empty=1; after release no stale beats appear.
